// File: rtl/lenet5_param_loader_if.sv
// Stream-in and memory-write-port bundle for the LeNet-5 parameter loader.
// slave = loader side, master = stream source / memory side.
interface lenet5_param_loader_if #(
   parameter int W_BW  = 8,
   parameter int B_BW  = 16,
   parameter int I_BW1 = 8,
   parameter int N_W   = 5110,
   parameter int N_B   = 10,
   parameter int N_PIX = 784
);
   localparam int AW_W = $clog2(N_W);
   localparam int AW_B = $clog2(N_B);
   localparam int AW_F = $clog2(N_PIX);

   logic             ce;
   logic [W_BW-1:0]  i_weight;
   logic [B_BW-1:0]  i_bias_fc;
   logic [I_BW1-1:0] i_fmap;
   logic             i_rst_processEnd;
   logic             i_reload;

   logic             o_w_we;
   logic [AW_W-1:0]  o_w_addr;
   logic [W_BW-1:0]  o_w_data;
   logic             o_b_we;
   logic [AW_B-1:0]  o_b_addr;
   logic [B_BW-1:0]  o_b_data;
   logic             o_f_we;
   logic [AW_F-1:0]  o_f_addr;
   logic [I_BW1-1:0] o_f_data;
   logic [1:0]       o_phase;
   logic             o_param_valid;
   logic             o_start;

   modport slave (
      input  ce, i_weight, i_bias_fc, i_fmap, i_rst_processEnd, i_reload,
      output o_w_we, o_w_addr, o_w_data, o_b_we, o_b_addr, o_b_data,
             o_f_we, o_f_addr, o_f_data, o_phase, o_param_valid, o_start
   );

   modport master (
      output ce, i_weight, i_bias_fc, i_fmap, i_rst_processEnd, i_reload,
      input  o_w_we, o_w_addr, o_w_data, o_b_we, o_b_addr, o_b_data,
             o_f_we, o_f_addr, o_f_data, o_phase, o_param_valid, o_start
   );
endinterface

// File: rtl/lenet5_param_loader.sv
// Loads weights, FC biases, then one image into on-chip memories; 1-cycle write latency.
// No backpressure: every ce=1 word is taken (dropped in READY or under i_reload).
module lenet5_param_loader #(
   parameter int W_BW  = 8,
   parameter int B_BW  = 16,
   parameter int I_BW1 = 8,
   parameter int N_W   = 5110,
   parameter int N_B   = 10,
   parameter int N_PIX = 784
) (
   input  logic clk,
   input  logic global_rst,
   lenet5_param_loader_if.slave bus
);
   localparam int AW_W  = $clog2(N_W);
   localparam int AW_B  = $clog2(N_B);
   localparam int AW_F  = $clog2(N_PIX);
   localparam int CW_WB = (AW_W > AW_B) ? AW_W : AW_B;
   localparam int CW    = (CW_WB > AW_F) ? CW_WB : AW_F;

   typedef enum logic [1:0] {
      WEIGHT = 2'd0,
      BIAS   = 2'd1,
      FMAP   = 2'd2,
      READY  = 2'd3
   } phase_t;

   phase_t           phase, phase_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             w_we, w_we_n, b_we, b_we_n, f_we, f_we_n;
   logic [AW_W-1:0]  w_addr, w_addr_n;
   logic [AW_B-1:0]  b_addr, b_addr_n;
   logic [AW_F-1:0]  f_addr, f_addr_n;
   logic [W_BW-1:0]  w_data, w_data_n;
   logic [B_BW-1:0]  b_data, b_data_n;
   logic [I_BW1-1:0] f_data, f_data_n;
   logic             param_valid, param_valid_n;
   logic             start, start_n;

   always_ff @(posedge clk) begin
      if (global_rst) begin
         phase       <= WEIGHT;
         cnt         <= '0;
         w_we        <= 1'b0;
         w_addr      <= '0;
         w_data      <= '0;
         b_we        <= 1'b0;
         b_addr      <= '0;
         b_data      <= '0;
         f_we        <= 1'b0;
         f_addr      <= '0;
         f_data      <= '0;
         param_valid <= 1'b0;
         start       <= 1'b0;
      end else begin
         phase       <= phase_n;
         cnt         <= cnt_n;
         w_we        <= w_we_n;
         w_addr      <= w_addr_n;
         w_data      <= w_data_n;
         b_we        <= b_we_n;
         b_addr      <= b_addr_n;
         b_data      <= b_data_n;
         f_we        <= f_we_n;
         f_addr      <= f_addr_n;
         f_data      <= f_data_n;
         param_valid <= param_valid_n;
         start       <= start_n;
      end
   end

   // One shared counter; it is cleared on every phase change so it only ever spans one memory.
   always_comb begin
      phase_n       = phase;
      cnt_n         = cnt;
      w_we_n        = 1'b0;
      w_addr_n      = w_addr;
      w_data_n      = w_data;
      b_we_n        = 1'b0;
      b_addr_n      = b_addr;
      b_data_n      = b_data;
      f_we_n        = 1'b0;
      f_addr_n      = f_addr;
      f_data_n      = f_data;
      param_valid_n = param_valid;
      start_n       = 1'b0;

      if (bus.i_reload) begin
         phase_n       = WEIGHT;
         cnt_n         = '0;
         param_valid_n = 1'b0;
      end else begin
         case (phase)
            WEIGHT: if (bus.ce) begin
               w_we_n   = 1'b1;
               w_addr_n = cnt[AW_W-1:0];
               w_data_n = bus.i_weight;
               if (cnt == CW'(N_W - 1)) begin
                  phase_n = BIAS;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            BIAS: if (bus.ce) begin
               b_we_n   = 1'b1;
               b_addr_n = cnt[AW_B-1:0];
               b_data_n = bus.i_bias_fc;
               if (cnt == CW'(N_B - 1)) begin
                  phase_n       = FMAP;
                  cnt_n         = '0;
                  param_valid_n = 1'b1;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            FMAP: if (bus.ce) begin
               f_we_n   = 1'b1;
               f_addr_n = cnt[AW_F-1:0];
               f_data_n = bus.i_fmap;
               if (cnt == CW'(N_PIX - 1)) begin
                  phase_n = READY;
                  cnt_n   = '0;
                  start_n = 1'b1;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            READY: if (bus.i_rst_processEnd) begin
               phase_n = FMAP;
               cnt_n   = '0;
            end
            default: phase_n = WEIGHT;
         endcase
      end
   end

   assign bus.o_w_we        = w_we;
   assign bus.o_w_addr      = w_addr;
   assign bus.o_w_data      = w_data;
   assign bus.o_b_we        = b_we;
   assign bus.o_b_addr      = b_addr;
   assign bus.o_b_data      = b_data;
   assign bus.o_f_we        = f_we;
   assign bus.o_f_addr      = f_addr;
   assign bus.o_f_data      = f_data;
   assign bus.o_phase       = phase;
   assign bus.o_param_valid = param_valid;
   assign bus.o_start       = start;
endmodule

// File: tb/tb_lenet5_param_loader.sv
// Directed bench: small instance (4/2/3) for sequencing, default instance for a full load count.
module tb_lenet5_param_loader;
   logic clk;
   logic global_rst;
   int   checks;
   int   errors;

   lenet5_param_loader_if #(.N_W(4), .N_B(2), .N_PIX(3)) sb ();
   lenet5_param_loader_if bb ();

   lenet5_param_loader #(.N_W(4), .N_B(2), .N_PIX(3)) dut_s (
      .clk(clk), .global_rst(global_rst), .bus(sb.slave)
   );
   lenet5_param_loader dut_b (
      .clk(clk), .global_rst(global_rst), .bus(bb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ce;
      logic [7:0]  w;
      logic [15:0] b;
      logic [7:0]  f;
      logic        pend;
      logic [1:0]  port;   // 0 none, 1 weight, 2 bias, 3 fmap
      logic [3:0]  addr;
      logic [15:0] data;
      logic [1:0]  ph;
      logic        pv;
      logic        st;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input int ce, input int w, input int b, input int f,
                               input int pend, input int port, input int addr,
                               input int data, input int ph, input int pv, input int st);
      vec_t v;
      v.ce   = ce[0];
      v.w    = w[7:0];
      v.b    = b[15:0];
      v.f    = f[7:0];
      v.pend = pend[0];
      v.port = port[1:0];
      v.addr = addr[3:0];
      v.data = data[15:0];
      v.ph   = ph[1:0];
      v.pv   = pv[0];
      v.st   = st[0];
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sb.ce = 1'b0; sb.i_weight = '0; sb.i_bias_fc = '0; sb.i_fmap = '0;
      sb.i_rst_processEnd = 1'b0; sb.i_reload = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " w_we"},   32'(sb.o_w_we), 0);
      check({tag, " w_addr"}, 32'(sb.o_w_addr), 0);
      check({tag, " w_data"}, 32'(sb.o_w_data), 0);
      check({tag, " b_we"},   32'(sb.o_b_we), 0);
      check({tag, " b_addr"}, 32'(sb.o_b_addr), 0);
      check({tag, " b_data"}, 32'(sb.o_b_data), 0);
      check({tag, " f_we"},   32'(sb.o_f_we), 0);
      check({tag, " f_addr"}, 32'(sb.o_f_addr), 0);
      check({tag, " f_data"}, 32'(sb.o_f_data), 0);
      check({tag, " phase"},  32'(sb.o_phase), 0);
      check({tag, " pvalid"}, 32'(sb.o_param_valid), 0);
      check({tag, " start"},  32'(sb.o_start), 0);
   endtask

   initial begin
      int nw;
      int n_w, n_b, n_f, n_st, order_err;
      checks = 0;
      errors = 0;
      idle_inputs();
      bb.ce = 1'b0; bb.i_weight = '0; bb.i_bias_fc = '0; bb.i_fmap = '0;
      bb.i_rst_processEnd = 1'b0; bb.i_reload = 1'b0;

      // Continuous load, READY ignoring ce, then a second image.
      tbl[0]  = mk(1, 11, 0, 0, 0, 1, 0, 11, 0, 0, 0);
      tbl[1]  = mk(1, 12, 0, 0, 0, 1, 1, 12, 0, 0, 0);
      tbl[2]  = mk(1, 13, 0, 0, 0, 1, 2, 13, 0, 0, 0);
      tbl[3]  = mk(1, 14, 0, 0, 0, 1, 3, 14, 1, 0, 0);
      tbl[4]  = mk(1, 0, 'h0101, 0, 0, 2, 0, 'h0101, 1, 0, 0);
      tbl[5]  = mk(1, 0, 'h0202, 0, 0, 2, 1, 'h0202, 2, 1, 0);
      tbl[6]  = mk(1, 0, 0, 7, 0, 3, 0, 7, 2, 1, 0);
      tbl[7]  = mk(1, 0, 0, 8, 0, 3, 1, 8, 2, 1, 0);
      tbl[8]  = mk(1, 0, 0, 9, 0, 3, 2, 9, 3, 1, 1);
      for (int i = 9; i < 14; i++) tbl[i] = mk(1, 'h33, 'h4444, 'hEE, 0, 0, 0, 0, 3, 1, 0);
      tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0);
      tbl[15] = mk(1, 0, 0, 1, 0, 3, 0, 1, 2, 1, 0);
      tbl[16] = mk(1, 0, 0, 2, 1, 3, 1, 2, 2, 1, 0);
      tbl[17] = mk(1, 0, 0, 3, 0, 3, 2, 3, 3, 1, 1);

      global_rst = 1'b1;
      tick();
      tick();
      check_all_zero("reset");
      global_rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         sb.ce = tbl[i].ce; sb.i_weight = tbl[i].w; sb.i_bias_fc = tbl[i].b;
         sb.i_fmap = tbl[i].f; sb.i_rst_processEnd = tbl[i].pend;
         tick();
         check($sformatf("v%0d w_we", i), 32'(sb.o_w_we), 32'(tbl[i].port == 2'd1));
         check($sformatf("v%0d b_we", i), 32'(sb.o_b_we), 32'(tbl[i].port == 2'd2));
         check($sformatf("v%0d f_we", i), 32'(sb.o_f_we), 32'(tbl[i].port == 2'd3));
         if (tbl[i].port == 2'd1) begin
            check($sformatf("v%0d w_addr", i), 32'(sb.o_w_addr), 32'(tbl[i].addr));
            check($sformatf("v%0d w_data", i), 32'(sb.o_w_data), 32'(tbl[i].data));
         end else if (tbl[i].port == 2'd2) begin
            check($sformatf("v%0d b_addr", i), 32'(sb.o_b_addr), 32'(tbl[i].addr));
            check($sformatf("v%0d b_data", i), 32'(sb.o_b_data), 32'(tbl[i].data));
         end else if (tbl[i].port == 2'd3) begin
            check($sformatf("v%0d f_addr", i), 32'(sb.o_f_addr), 32'(tbl[i].addr));
            check($sformatf("v%0d f_data", i), 32'(sb.o_f_data), 32'(tbl[i].data));
         end
         check($sformatf("v%0d phase", i),  32'(sb.o_phase), 32'(tbl[i].ph));
         check($sformatf("v%0d pvalid", i), 32'(sb.o_param_valid), 32'(tbl[i].pv));
         check($sformatf("v%0d start", i),  32'(sb.o_start), 32'(tbl[i].st));
      end
      idle_inputs();

      // ce toggling during the weight phase.
      global_rst = 1'b1;
      tick();
      global_rst = 1'b0;
      nw = 0;
      for (int i = 0; i < 8; i++) begin
         sb.ce = (i % 2 == 0);
         sb.i_weight = 8'(20 + i);
         tick();
         if (sb.o_w_we) begin
            check($sformatf("toggle addr %0d", nw), 32'(sb.o_w_addr), 32'(nw));
            nw++;
         end
         check($sformatf("toggle phase c%0d", i), 32'(sb.o_phase), (nw == 4) ? 1 : 0);
      end
      check("toggle write count", 32'(nw), 4);

      // Reload coincident with the second bias.
      sb.ce = 1'b1; sb.i_bias_fc = 16'h0A0A;
      tick();
      check("bias0 b_we", 32'(sb.o_b_we), 1);
      check("bias0 b_addr", 32'(sb.o_b_addr), 0);
      sb.i_bias_fc = 16'h0B0B; sb.i_reload = 1'b1;
      tick();
      check("reload b_we", 32'(sb.o_b_we), 0);
      check("reload phase", 32'(sb.o_phase), 0);
      check("reload pvalid", 32'(sb.o_param_valid), 0);
      sb.i_reload = 1'b0; sb.i_weight = 8'h55;
      tick();
      check("post-reload w_we", 32'(sb.o_w_we), 1);
      check("post-reload w_addr", 32'(sb.o_w_addr), 0);
      check("post-reload w_data", 32'(sb.o_w_data), 32'h55);
      idle_inputs();

      // Reset after two pixels.
      global_rst = 1'b1;
      tick();
      global_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sb.ce = 1'b1;
         sb.i_weight = 8'(i + 1); sb.i_bias_fc = 16'(i + 1); sb.i_fmap = 8'(i + 1);
         tick();
      end
      check("pre-reset phase", 32'(sb.o_phase), 2);
      check("pre-reset f_addr", 32'(sb.o_f_addr), 1);
      global_rst = 1'b1; sb.i_fmap = 8'hAB;
      tick();
      check_all_zero("midreset");
      global_rst = 1'b0; sb.i_weight = 8'h77;
      tick();
      check("restart w_addr", 32'(sb.o_w_addr), 0);
      check("restart w_data", 32'(sb.o_w_data), 32'h77);
      check("restart phase", 32'(sb.o_phase), 0);
      idle_inputs();

      // Full load with default sizes, bounded by a cycle budget.
      global_rst = 1'b1;
      tick();
      global_rst = 1'b0;
      n_w = 0; n_b = 0; n_f = 0; n_st = 0; order_err = 0;
      for (int c = 0; c < 6200 && n_st == 0; c++) begin
         bb.ce = 1'b1;
         bb.i_weight = c[7:0]; bb.i_bias_fc = c[15:0]; bb.i_fmap = c[7:0];
         tick();
         if (bb.o_w_we) begin
            if (32'(bb.o_w_addr) != n_w) order_err++;
            n_w++;
         end
         if (bb.o_b_we) begin
            if (32'(bb.o_b_addr) != n_b) order_err++;
            n_b++;
         end
         if (bb.o_f_we) begin
            if (32'(bb.o_f_addr) != n_f) order_err++;
            n_f++;
         end
         if (bb.o_start) n_st++;
      end
      bb.ce = 1'b0;
      tick();
      check("full start seen", 32'(n_st), 1);
      check("full weight writes", 32'(n_w), 5110);
      check("full bias writes", 32'(n_b), 10);
      check("full fmap writes", 32'(n_f), 784);
      check("full total writes", 32'(n_w + n_b + n_f), 5904);
      check("full addr order errors", 32'(order_err), 0);
      check("full phase", 32'(bb.o_phase), 3);
      check("full pvalid", 32'(bb.o_param_valid), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lenet5_param_loader.md
LENET5_PARAM_LOADER -- requirements
Module: lenet5_param_loader

Interface
REQ-001 Parameter W_BW, 8: weight word width in bits.
REQ-002 Parameter B_BW, 16: FC bias word width in bits.
REQ-003 Parameter I_BW1, 8: input pixel width in bits.
REQ-004 Parameter N_W, 5110: total weight count (conv1 150 + conv2 2400 + FC 2560).
REQ-005 Parameter N_B, 10: FC bias count.
REQ-006 Parameter N_PIX, 784: pixels per image (28x28).
REQ-007 Address widths SHALL be AW_W=clog2(N_W), AW_B=clog2(N_B), AW_F=clog2(N_PIX), using the team's clog2 include.
REQ-008 One clock; reset is synchronous and active-high.
REQ-009 clk  in  1  rising-edge clock for all state.
REQ-010 global_rst  in  1  synchronous active-high reset.
REQ-011 ce  in  1  stream valid; one word is accepted on every clk edge where ce=1.
REQ-012 i_weight  in  W_BW  weight word, sampled only in phase WEIGHT.
REQ-013 i_bias_fc  in  B_BW  bias word, sampled only in phase BIAS.
REQ-014 i_fmap  in  I_BW1  pixel word, sampled only in phase FMAP.
REQ-015 i_rst_processEnd  in  1  pulse; the current inference is finished, so the block accepts the next image.
REQ-016 i_reload  in  1  pulse; discard all progress and reload the weights.
REQ-017 o_w_we/o_w_addr/o_w_data  out  1/AW_W/W_BW  weight memory write port.
REQ-018 o_b_we/o_b_addr/o_b_data  out  1/AW_B/B_BW  bias memory write port.
REQ-019 o_f_we/o_f_addr/o_f_data  out  1/AW_F/I_BW1  fmap memory write port.
REQ-020 o_phase  out  2  current state: 0=WEIGHT, 1=BIAS, 2=FMAP, 3=READY.
REQ-021 o_param_valid  out  1  high while the weights and biases are fully loaded.
REQ-022 o_start  out  1  one-cycle pulse; the image is complete and inference may begin.

Function
REQ-023 The FSM SHALL have the states WEIGHT -> BIAS -> FMAP -> READY, with a single counter per phase.
REQ-024 In a given phase, each ce=1 cycle SHALL register one write: we=1, addr=count, data=sampled bus, visible on the following cycle (latency 1).
REQ-025 Write enables SHALL be high for exactly one cycle per accepted word, and low when ce=0.
REQ-026 Addresses SHALL increment from 0 to N-1 with no gaps, in stream order.
REQ-027 When the word at N_W-1 is accepted, the block SHALL enter BIAS on the next cycle and clear the counter; the first bias is accepted on the following ce.
REQ-028 When the word at N_B-1 is accepted, the block SHALL enter FMAP and o_param_valid SHALL go to 1.
REQ-029 When the pixel at N_PIX-1 is accepted, the block SHALL enter READY and pulse o_start for 1 cycle, coincident with the last o_f_we.
REQ-030 In READY, ce SHALL be ignored: no writes and no counting.
REQ-031 In READY, i_rst_processEnd SHALL return the block to FMAP with the pixel counter set to 0, while weights, biases and o_param_valid are retained.
REQ-032 i_rst_processEnd outside READY SHALL be ignored.
REQ-033 i_reload in any state SHALL go to WEIGHT, clear all counters, clear o_param_valid, and suppress any write in that cycle.
REQ-034 If i_reload and i_rst_processEnd are asserted together, i_reload SHALL win.
REQ-035 If i_reload and ce are asserted together, the word SHALL be dropped.
REQ-036 Counters SHALL never exceed N-1; no wrap-around is allowed within a phase.

Reset
REQ-037 global_rst=1 at a clock edge SHALL set o_phase=0, all counters=0, and all we, addr, data, o_param_valid and o_start to 0.
REQ-038 Reset asserted mid-phase SHALL abort the load in progress, and after release the load SHALL restart at weight address 0.
REQ-039 global_rst SHALL take priority over every other input.

Verification (N_W=4, N_B=2, N_PIX=3 unless stated)
REQ-040 Continuous ce with weights 11,12,13,14, biases 0x0101,0x0202 and pixels 7,8,9: writes land at weight addresses 0-3, bias addresses 0-1 and fmap addresses 0-2 with matching data; o_start pulses once, coincident with pixel 9; o_phase=3.
REQ-041 ce toggling 1/0 during the weight phase: exactly 4 weight writes occur, addresses contain no gaps, and the phase changes only after the 4th write.
REQ-042 In READY, ce held high for 5 cycles causes 0 writes; then i_rst_processEnd followed by pixels 1,2,3 writes fmap addresses 0-2, o_param_valid stays 1, and o_start pulses again.
REQ-043 i_reload asserted in the same cycle as a ce on the 2nd bias: no bias write occurs, o_phase=0 next cycle, o_param_valid=0, and the next weight goes to address 0.
REQ-044 global_rst asserted after 2 pixels: all outputs are 0 next cycle, and a full reload with default parameters (5110/10/784) completes with exactly 5904 writes.
